// File: rtl/uart_rx_deserializer_if.sv
// Parallel-side bus of the UART receiver: received byte, valid/ack handshake and error pulses.
// master is the receiver, slave is the byte consumer.
interface uart_rx_deserializer_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART 8N1-style receiver: synchronises rx_in, samples each bit at its centre and delivers
// bytes over a valid/ack bus with framing-error and overrun pulses.
module uart_rx_deserializer #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_in,
    output logic                   busy,
    uart_rx_deserializer_if.master bus
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = $clog2(DATA_BITS);

    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 armed_q, armed_d;
    logic                 good_q, good_d;
    logic                 bad_q, bad_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_s;

    assign sync_d = {sync_q[0], rx_in};
    assign rx_s   = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        armed_d = armed_q;
        good_d  = 1'b0;
        bad_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // A held-low line after a framing error must go high before a new start counts.
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    state_d = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IdxLast) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    state_d = StIdle;
                    if (rx_s) begin
                        good_d = 1'b1;
                    end else begin
                        bad_d   = 1'b1;
                        armed_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
            idx_d = '0;
        end
    end

    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = bad_q;
        overrun_d   = 1'b0;
        if (rx_valid_q && bus.rx_ack) begin
            rx_valid_d = 1'b0;
        end
        // shift_q is still intact here: the next frame cannot reach DATA for half a bit.
        if (good_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q && !bus.rx_ack;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            armed_q     <= 1'b0;
            good_q      <= 1'b0;
            bad_q       <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: serial frames driven from a line model, output events
// checked against a timed expectation queue by an independent monitor.
module tb_uart_rx_deserializer;
    localparam int unsigned CPB = 8;
    localparam int unsigned DB  = 8;
    // Edges from the first edge seeing rx_in low to the edge loading rx_valid / frame_err.
    localparam longint LAT = 2 + CPB / 2 + (DB + 1) * CPB + 1;

    localparam int EvByte = 0;
    localparam int EvOvr  = 1;
    localparam int EvErr  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        longint     cyc;
    } ev_t;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    logic   rx_in = 1'b1;
    logic   busy;
    logic   auto_ack = 1'b0;
    logic   auto_pulse = 1'b0;
    logic   man_ack = 1'b0;
    longint cyc = 0;
    longint cur_k = 0;
    int     n_checks = 0;
    int     n_pass = 0;
    ev_t    exp_q[$];
    event   frame_started;

    uart_rx_deserializer_if #(.DATA_BITS(DB)) bus ();

    uart_rx_deserializer #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rx_in(rx_in),
        .busy (busy),
        .bus  (bus)
    );

    assign bus.rx_ack = auto_pulse | man_ack;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic void exp_push(input int kind, input logic [7:0] data, input longint c);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = c;
        exp_q.push_back(e);
    endfunction

    task automatic got_ev(input int kind, input logic [7:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: kind %0d data %0h at cycle %0d, required none",
                     kind, data, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (e.kind == EvByte) chk("event_data", data, e.data);
        end
    endtask

    // Line-level transmitter model: start, LSB-first data, stop, CPB clocks each.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic exp_ovr);
        longint k;
        @(negedge clk);
        rx_in = 1'b0;
        k     = cyc + 1;
        cur_k = k;
        ->frame_started;
        if (stop) begin
            exp_push(EvByte, b, k + LAT);
            if (exp_ovr) exp_push(EvOvr, 8'h00, k + LAT);
        end else begin
            exp_push(EvErr, 8'h00, k + LAT);
        end
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
    endtask

    // Monitor: turns DUT output activity into events and checks them against the queue.
    initial begin
        logic       prev_valid;
        logic [7:0] prev_data;
        prev_valid = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.rx_valid && (!prev_valid || bus.rx_data != prev_data))
                    got_ev(EvByte, bus.rx_data);
                if (bus.overrun) got_ev(EvOvr, 8'h00);
                if (bus.frame_err) got_ev(EvErr, 8'h00);
            end
            prev_valid = bus.rx_valid;
            prev_data  = bus.rx_data;
        end
    end

    // Consumer model: acknowledges three cycles after rx_valid is seen.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_ack && bus.rx_valid && !reset) begin
                repeat (2) @(negedge clk);
                auto_pulse = 1'b1;
                @(negedge clk);
                auto_pulse = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint k;
        int     n;
        int     gap;
        int     r;

        repeat (3) @(negedge clk);
        chk("reset_rx_valid", bus.rx_valid, 0);
        chk("reset_rx_data", bus.rx_data, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single frame with handshake timing.
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                @(frame_started);
                k = cur_k;
                while (cyc < k + 40) @(negedge clk);
                chk("busy_mid_frame", busy, 1);
                n = 0;
                while (!bus.rx_valid && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                chk("a5_valid_cycle", cyc, k + LAT);
                chk("a5_data", bus.rx_data, 8'hA5);
                chk("busy_after_frame", busy, 0);
                repeat (2) @(negedge clk);
                chk("valid_held_before_ack", bus.rx_valid, 1);
                man_ack = 1'b1;
                @(negedge clk);
                man_ack = 1'b0;
                chk("valid_fall_after_ack", bus.rx_valid, 0);
            end
        join
        repeat (5) @(negedge clk);

        // Short low glitch aborts at the mid-start sample.
        @(negedge clk);
        rx_in = 1'b0;
        k     = cyc + 1;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        chk("glitch_busy_rises", busy, 1);
        while (cyc < k + 10) @(negedge clk);
        chk("glitch_busy_clears", busy, 0);

        // Bad stop bit followed by a held break.
        send_frame(8'h3C, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            repeat (10) @(negedge clk);
            chk("break_no_start", busy, 0);
        end
        chk("break_no_valid", bus.rx_valid, 0);
        rx_in = 1'b1;
        repeat (10) @(negedge clk);

        // Back-to-back, no ack: overrun on the second load.
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        chk("ovr_data", bus.rx_data, 8'h22);
        chk("ovr_valid", bus.rx_valid, 1);
        pulse_ack();
        chk("ovr_ack_clears", bus.rx_valid, 0);

        // Back-to-back with ack on the load cycle: no overrun.
        send_frame(8'h33, 1'b1, 1'b0);
        fork
            send_frame(8'h44, 1'b1, 1'b0);
            begin
                @(frame_started);
                k = cur_k;
                while (cyc < k + LAT - 1) @(negedge clk);
                man_ack = 1'b1;
                @(negedge clk);
                man_ack = 1'b0;
            end
        join
        chk("ackload_data", bus.rx_data, 8'h44);
        chk("ackload_valid", bus.rx_valid, 1);
        pulse_ack();
        repeat (4) @(negedge clk);

        // Reset during data bit 4 of 0xFF.
        auto_ack = 1'b1;
        @(negedge clk);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
        repeat (CPB * 4 + CPB / 2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_valid", bus.rx_valid, 0);
        chk("rst_mid_data", bus.rx_data, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ferr", bus.frame_err, 0);
        chk("rst_mid_ovr", bus.overrun, 0);
        reset = 1'b0;
        repeat (CPB * 4) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b0);

        // Loopback stream from a transmitter.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h80, 1'b1, 1'b0);
        repeat (6) @(negedge clk);

        // Randomised frames, bad stops and glitches.
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0) begin
                @(negedge clk);
                rx_in = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rx_in = 1'b1;
                repeat (12) @(negedge clk);
            end else begin
                send_frame(8'($urandom), (r != 1), 1'b0);
                gap   = (r != 1) ? $urandom_range(0, 12) : $urandom_range(4, 12);
                rx_in = 1'b1;
                repeat (gap) @(negedge clk);
            end
        end

        repeat (200) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
